// File: rtl/osd_spi_master.sv
// SPI master driving the OSD overlay link: enable/disable commands and full-line
// bitmap writes, with column bytes pulled from a 1-cycle-latency byte source.
module osd_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_line,
  output logic       byte_req,
  output logic [6:0] byte_addr,
  input  logic [7:0] byte_data,
  output logic       sck,
  output logic       ss,
  output logic       sdi,
  output logic       done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam bit         HAS_GAP  = (GAP > 0);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_FETCH, S_TAIL, S_GAP} state_t;

  state_t      state_r, state_s;
  logic [7:0]  div_r, div_s;
  logic [2:0]  bit_r, bit_s;
  logic [8:0]  idx_r, idx_s;     // 0 = command byte, 1..256 = payload bytes
  logic [7:0]  data_r, data_s;
  logic        write_r, write_s;
  logic        nop_r, nop_s;
  logic        fsub_r, fsub_s;
  logic        cmd_ready_r, cmd_ready_s;
  logic        byte_req_r, byte_req_s;
  logic [6:0]  byte_addr_r, byte_addr_s;
  logic        sck_r, sck_s;
  logic        ss_r, ss_s;
  logic        sdi_r, sdi_s;
  logic        done_r, done_s;
  logic [7:0]  cmd_byte_s;

  assign cmd_ready = cmd_ready_r;
  assign byte_req  = byte_req_r;
  assign byte_addr = byte_addr_r;
  assign sck       = sck_r;
  assign ss        = ss_r;
  assign sdi       = sdi_r;
  assign done      = done_r;

  // Command byte for the requested operation.
  always_comb begin
    cmd_byte_s = 8'h00;
    case (cmd_op)
      2'd0:    cmd_byte_s = 8'h40;
      2'd1:    cmd_byte_s = 8'h41;
      2'd2:    cmd_byte_s = {5'b00100, cmd_line};
      default: cmd_byte_s = 8'h00;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    bit_s       = bit_r;
    idx_s       = idx_r;
    data_s      = data_r;
    write_s     = write_r;
    nop_s       = nop_r;
    fsub_s      = fsub_r;
    cmd_ready_s = cmd_ready_r;
    byte_req_s  = 1'b0;
    byte_addr_s = byte_addr_r;
    sck_s       = sck_r;
    ss_s        = ss_r;
    sdi_s       = sdi_r;
    done_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          cmd_ready_s = 1'b0;
          write_s     = (cmd_op == 2'd2);
          if (cmd_op == 2'd3) begin
            state_s = S_GAP;
            nop_s   = 1'b1;
            done_s  = 1'b1;
          end else begin
            state_s = S_SHIFT;
            nop_s   = 1'b0;
            ss_s    = 1'b0;
            sck_s   = 1'b0;
            data_s  = cmd_byte_s;
            sdi_s   = cmd_byte_s[7];
            bit_s   = 3'd7;
            div_s   = 8'd0;
            idx_s   = 9'd0;
          end
        end else begin
          cmd_ready_s = 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_r == DIV_LAST) begin
          div_s = 8'd0;
          if (!sck_r) begin
            sck_s = 1'b1;
          end else begin
            sck_s = 1'b0;
            if (bit_r != 3'd0) begin
              bit_s = bit_r - 3'd1;
              sdi_s = data_r[bit_r - 3'd1];
            end else begin
              idx_s = idx_r + 9'd1;
              bit_s = 3'd7;
              if (!write_r || idx_r == 9'd256) begin
                state_s = S_TAIL;
              end else if (!idx_r[0]) begin
                // Even payload index: fetch a new column; odd index resends it.
                state_s     = S_FETCH;
                fsub_s      = 1'b0;
                byte_req_s  = 1'b1;
                byte_addr_s = idx_r[7:1];
              end else begin
                sdi_s = data_r[7];
              end
            end
          end
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      S_FETCH: begin
        if (!fsub_r) begin
          fsub_s = 1'b1;
        end else begin
          state_s = S_SHIFT;
          data_s  = byte_data;
          sdi_s   = byte_data[7];
          div_s   = 8'd0;
          bit_s   = 3'd7;
          fsub_s  = 1'b0;
        end
      end
      S_TAIL: begin
        if (div_r == DIV_LAST) begin
          ss_s  = 1'b1;
          div_s = 8'd0;
          if (HAS_GAP) begin
            state_s = S_GAP;
          end else begin
            state_s     = S_IDLE;
            done_s      = 1'b1;
            cmd_ready_s = 1'b1;
            byte_addr_s = write_r ? byte_addr_r + 7'd1 : byte_addr_r;
          end
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      S_GAP: begin
        if (nop_r) begin
          state_s     = S_IDLE;
          cmd_ready_s = 1'b1;
        end else if (div_r == GAP_LAST) begin
          state_s     = S_IDLE;
          done_s      = 1'b1;
          cmd_ready_s = 1'b1;
          byte_addr_s = write_r ? byte_addr_r + 7'd1 : byte_addr_r;
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      default: begin
        state_s     = S_IDLE;
        ss_s        = 1'b1;
        sck_s       = 1'b0;
        cmd_ready_s = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      div_r       <= 8'd0;
      bit_r       <= 3'd0;
      idx_r       <= 9'd0;
      data_r      <= 8'd0;
      write_r     <= 1'b0;
      nop_r       <= 1'b0;
      fsub_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      byte_req_r  <= 1'b0;
      byte_addr_r <= 7'd0;
      sck_r       <= 1'b0;
      ss_r        <= 1'b1;
      sdi_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      bit_r       <= bit_s;
      idx_r       <= idx_s;
      data_r      <= data_s;
      write_r     <= write_s;
      nop_r       <= nop_s;
      fsub_r      <= fsub_s;
      cmd_ready_r <= cmd_ready_s;
      byte_req_r  <= byte_req_s;
      byte_addr_r <= byte_addr_s;
      sck_r       <= sck_s;
      ss_r        <= ss_s;
      sdi_r       <= sdi_s;
      done_r      <= done_s;
    end
  end

endmodule

// File: tb/tb_osd_spi_master.sv
// Bench for osd_spi_master: SPI byte scoreboard, overlay enable model, byte source
// model, and timing checks at CLK_DIV=2/GAP=2 plus CLK_DIV=1/GAP=0.
module tb_osd_spi_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, byte_req, sck, ss, sdi, done;
  logic [1:0] cmd_op;
  logic [2:0] cmd_line;
  logic [6:0] byte_addr;
  logic [7:0] byte_data;

  logic       cmd_valid_b, cmd_ready_b, byte_req_b, sck_b, ss_b, sdi_b, done_b;
  logic [1:0] cmd_op_b;
  logic [2:0] cmd_line_b;
  logic [6:0] byte_addr_b;
  logic [7:0] byte_data_b;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sh;
  logic       prev_sck = 1'b0;
  logic       osd_en = 1'b0;
  int bitc = 0, fbytes = 0, rises = 0, done_cnt = 0, req_cnt = 0, exp_addr = 0;

  osd_spi_master #(.CLK_DIV(2), .GAP(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_line(cmd_line), .byte_req(byte_req), .byte_addr(byte_addr),
    .byte_data(byte_data), .sck(sck), .ss(ss), .sdi(sdi), .done(done)
  );

  osd_spi_master #(.CLK_DIV(1), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op_b), .cmd_line(cmd_line_b), .byte_req(byte_req_b), .byte_addr(byte_addr_b),
    .byte_data(byte_data_b), .sck(sck_b), .ss(ss_b), .sdi(sdi_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Synchronous byte source with one cycle of read latency.
  always @(posedge clk) begin
    if (byte_req) byte_data <= {1'b0, byte_addr} ^ 8'hA5;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI decoder, overlay enable model, scoreboard pop and byte-source address checks.
  initial begin
    forever begin
      @(negedge clk);
      if (ss) begin
        bitc   = 0;
        fbytes = 0;
      end else if (sck && !prev_sck) begin
        sh = {sh[6:0], sdi};
        bitc++;
        rises++;
        if (bitc == 8) begin
          bitc = 0;
          if (fbytes == 0 && sh == 8'h41) osd_en = 1'b1;
          if (fbytes == 0 && sh == 8'h40) osd_en = 1'b0;
          fbytes++;
          if (exp_q.size() > 0) check("spi_byte", sh, exp_q.pop_front());
          else check("spi_byte_extra", {24'h0, sh}, 32'hFFFF_FFFF);
        end
      end
      prev_sck = sck;
      if (done) done_cnt++;
      if (byte_req) begin
        check("byte_addr", byte_addr, exp_addr);
        exp_addr++;
        req_cnt++;
      end
    end
  end

  function automatic logic [7:0] first_byte(input logic [1:0] op, input logic [2:0] line);
    case (op)
      2'd0:    return 8'h40;
      2'd1:    return 8'h41;
      2'd2:    return 8'h20 | {5'd0, line};
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_expected(input logic [1:0] op, input logic [2:0] line);
    if (op != 2'd3) exp_q.push_back(first_byte(op, line));
    if (op == 2'd2) begin
      for (int c = 0; c < 128; c++) begin
        exp_q.push_back(8'(c) ^ 8'hA5);
        exp_q.push_back(8'(c) ^ 8'hA5);
      end
    end
  endtask

  // Issue one command on the D=2/G=2 instance from a negedge and time it to done.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] line, input bit hold,
                         input int exp_done, input logic exp_rdy);
    int first_lo = 0, last_lo = 0, done_at = 0, r0, nbytes;
    nbytes = (op == 2'd3) ? 0 : (op == 2'd2) ? 257 : 1;
    r0 = rises;
    push_expected(op, line);
    check("rdy_at_accept", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_line  = line;
    for (int n = 1; n <= exp_done + 50 && done_at == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (!hold) cmd_valid = 1'b0;
        check("rdy_drop", cmd_ready, 1'b0);
        check("sdi_first", sdi, (op == 2'd3) ? 1'b0 : first_byte(op, line) >> 7);
      end
      if (!ss) begin
        if (first_lo == 0) first_lo = n;
        last_lo = n;
      end
      if (done) begin
        done_at   = n;
        cmd_valid = 1'b0;
        check("rdy_at_done", cmd_ready, exp_rdy);
      end
    end
    check("done_cycle", done_at, exp_done);
    check("ss_first_low", first_lo, (op == 2'd3) ? 0 : 1);
    check("ss_last_low", last_lo, (op == 2'd3) ? 0 : exp_done - 2 - 1);
    check("sck_rises", rises - r0, 8 * nbytes);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int r0, d0, db1, db2, hi;
    bit found;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_line = 3'd0;
    cmd_valid_b = 1'b0; cmd_op_b = 2'd0; cmd_line_b = 3'd0; byte_data_b = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ss", ss, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_sdi", sdi, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_byte_req", byte_req, 1'b0);
    check("rst_byte_addr", byte_addr, 7'd0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Enable then disable back-to-back: 1 + 16*2 + 2 + 2 = 37 cycles each.
    run_cmd(2'd1, 3'd0, 1'b0, 37, 1'b1);
    check("osd_enable_on", osd_en, 1'b1);
    run_cmd(2'd0, 3'd0, 1'b0, 37, 1'b1);
    check("osd_enable_off", osd_en, 1'b0);
    @(negedge clk);

    // Reserved op: no SPI activity, done at T+1, ready back at T+2.
    run_cmd(2'd3, 3'd0, 1'b0, 1, 1'b0);
    @(negedge clk);
    check("nop_ready_back", cmd_ready, 1'b1);
    check("nop_done_once", done, 1'b0);

    // Write line 5 with cmd_valid held throughout: 1 + 257*32 + 256 + 2 + 2 = 8485.
    exp_addr = 0;
    r0 = req_cnt;
    d0 = done_cnt;
    run_cmd(2'd2, 3'd5, 1'b1, 8485, 1'b1);
    check("byte_req_count", req_cnt - r0, 128);
    @(negedge clk);
    check("write_single_ss", ss, 1'b1);
    check("write_single_done", done_cnt - d0, 1);

    // Abort a write in the middle of payload byte 40 with an asynchronous reset.
    push_expected(2'd2, 3'd3);
    exp_addr = 0;
    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_line = 3'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20000 && !found; n++) begin
      @(negedge clk);
      #1;
      found = (fbytes == 41 && bitc == 2 && sck == 1'b1 && ss == 1'b0);
    end
    check("abort_reached", found, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("abort_ss", ss, 1'b1);
    check("abort_sck", sck, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_no_done", done_cnt - d0, 0);
    run_cmd(2'd1, 3'd0, 1'b0, 37, 1'b1);
    check("abort_enable_again", osd_en, 1'b1);

    // CLK_DIV=1, GAP=0: 18-cycle enables back-to-back with one ss-high cycle.
    db1 = 0; db2 = 0; hi = 0;
    cmd_valid_b = 1'b1; cmd_op_b = 2'd1;
    for (int n = 1; n <= 80 && db2 == 0; n++) begin
      @(negedge clk);
      if (n == 19) cmd_valid_b = 1'b0;
      if (n <= 3) check("b_sck_period", sck_b, (n == 2) ? 1'b1 : 1'b0);
      if (n == 1) begin
        check("b_sdi_first", sdi_b, 1'b0);
        check("b_no_fetch", {byte_req_b, byte_addr_b}, 8'h00);
        check("b_ready_drop", cmd_ready_b, 1'b0);
      end
      if (n >= 2 && n < 36 && ss_b) hi++;
      if (done_b) begin
        if (db1 == 0) db1 = n;
        else db2 = n;
      end
    end
    check("b_done_first", db1, 18);
    check("b_done_second", db2, 36);
    check("b_ss_high_cycles", hi, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
